// File: rtl/uart_tx_framer.sv
// UART transmitter: input FIFO, bit timer and frame sequencer.
// Frames are sent back-to-back while words remain queued.
module uart_tx_framer #(
    parameter int CLK_DIV    = 651,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          busy,
    output logic                          baud_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          cnt_q;
    logic                 push, pop, empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    state_t               state_q, state_d;
    logic [CW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 tick, start;

    assign tx_ready   = (cnt_q != (AW+1)'(FIFO_DEPTH));
    assign empty      = (cnt_q == '0);
    assign push       = tx_valid && tx_ready && !rst;
    assign head       = mem_q[rd_q];
    assign head_par   = (PARITY == 1) ? ^head : ~^head;
    assign busy       = (state_q != S_IDLE);
    assign tick       = busy && (timer_q == CW'(CLK_DIV - 1));
    assign baud_tick  = tick;
    assign tx_serial  = tx_q;
    assign fifo_level = cnt_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        start   = 1'b0;
        pop     = 1'b0;
        if (busy) timer_d = tick ? '0 : timer_q + CW'(1);
        unique case (state_q)
            S_IDLE: start = !empty;
            S_START: if (tick) begin
                state_d = S_DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            S_DATA: if (tick) begin
                if (bit_q == 3'(DATA_BITS - 1)) begin
                    bit_d = '0;
                    if (PARITY != 0) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            S_PARITY: if (tick) begin
                state_d = S_STOP;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
            S_STOP: if (tick) begin
                if (bit_q == 3'(STOP_BITS - 1)) begin
                    state_d = S_IDLE;
                    start   = !empty;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Popping at the stop edge chains the next frame with no idle gap
        if (start) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = head;
            par_d   = head_par;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
